// File: rtl/muldiv_pkg.sv
// Purpose: shared op encodings, FSM state type and defaults for the HI/LO multiply/divide unit.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package muldiv_pkg;

    localparam logic [2:0] OP_NOP   = 3'b000;
    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;

    localparam int ITER_DEFAULT = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } state_t;

endpackage

// File: rtl/muldiv_hilo_unit_if.sv
// Purpose: issue/result bundle between the datapath (master) and the HI/LO unit (slave).
// Latency: n/a (wires only).
// Backpressure: the master must hold off issuing while busy is high; refused issues are dropped.
// Signals: start/op/a/b issue request; busy/done status; hi/lo architectural registers.
interface muldiv_hilo_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (output start, op, a, b, input busy, done, hi, lo);
    modport slave  (input start, op, a, b, output busy, done, hi, lo);
endinterface

// File: rtl/muldiv_sign_fix.sv
// Purpose: conditional two's-complement negation of a double-width and a single-width value.
// Latency: combinational.
// Backpressure: none.
// Ports: val_w/neg_w -> res_w (2*W bits); val_n/neg_n -> res_n (W bits).
module muldiv_sign_fix #(
    parameter int W = 32
) (
    input  logic [2*W-1:0] val_w,
    input  logic           neg_w,
    output logic [2*W-1:0] res_w,
    input  logic [W-1:0]   val_n,
    input  logic           neg_n,
    output logic [W-1:0]   res_n
);
    assign res_w = neg_w ? (~val_w + 1'b1) : val_w;
    assign res_n = neg_n ? (~val_n + 1'b1) : val_n;
endmodule

// File: rtl/muldiv_hilo_unit.sv
// Purpose: multi-cycle MULT/MULTU/DIV/DIVU engine owning HI/LO; MTHI/MTLO write in one cycle.
// Latency: start edge E0 -> ITER radix-2 steps -> HI/LO written and done pulsed at E0+ITER+1.
// Backpressure: busy high while an op is in flight; any start seen then is dropped.
// Ports: clk, reset_n (async active-low); bus (slave modport): start/op/a/b in, busy/done/hi/lo out.
module muldiv_hilo_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = ITER_DEFAULT,
    parameter int ITER  = WIDTH
) (
    input  logic                 clk,
    input  logic                 reset_n,
    muldiv_hilo_unit_if.slave    bus
);
    localparam int W     = WIDTH;
    localparam int CNT_W = $clog2(ITER + 1);

    state_t           state;
    state_t           state_nxt;
    logic [2*W-1:0]   acc;       // mult: {partial hi, multiplier}; div: {remainder, quotient}
    logic [W-1:0]     opnd;      // multiplicand or divisor magnitude
    logic [CNT_W-1:0] cnt;
    logic             is_div;
    logic             neg_hi;    // negate product (mult) or remainder (div)
    logic             neg_lo;    // negate quotient (div only)
    logic [W-1:0]     hi_q;
    logic [W-1:0]     lo_q;
    logic             done_q;

    // Issue decode
    logic mul_op, div_op, sgn_op, dz, issue;
    assign mul_op = (bus.op == OP_MULT) || (bus.op == OP_MULTU);
    assign div_op = (bus.op == OP_DIV)  || (bus.op == OP_DIVU);
    assign sgn_op = (bus.op == OP_MULT) || (bus.op == OP_DIV);
    assign dz     = div_op && (bus.b == '0);
    assign issue  = (state == ST_IDLE) && bus.start && (mul_op || div_op);

    // One sign-fix instance shared in time: operand magnitudes while idle,
    // result correction in FIX. The remainder rides in the upper half of the
    // wide path with a zero lower half, so negating the whole word negates it alone.
    logic [2*W-1:0] fx_val_w, fx_res_w;
    logic [W-1:0]   fx_val_n, fx_res_n;
    logic           fx_neg_w, fx_neg_n;

    always_comb begin
        fx_val_w = '0;
        fx_neg_w = 1'b0;
        fx_val_n = '0;
        fx_neg_n = 1'b0;
        if (state == ST_FIX) begin
            fx_val_w = is_div ? {acc[2*W-1:W], {W{1'b0}}} : acc;
            fx_neg_w = neg_hi;
            fx_val_n = acc[W-1:0];
            fx_neg_n = neg_lo;
        end else begin
            fx_val_w = {bus.b, {W{1'b0}}};
            fx_neg_w = sgn_op && bus.b[W-1];
            fx_val_n = bus.a;
            // Divide by zero keeps the raw dividend so it lands in HI unchanged.
            fx_neg_n = sgn_op && bus.a[W-1] && !dz;
        end
    end

    muldiv_sign_fix #(.W(W)) u_sign_fix (
        .val_w (fx_val_w),
        .neg_w (fx_neg_w),
        .res_w (fx_res_w),
        .val_n (fx_val_n),
        .neg_n (fx_neg_n),
        .res_n (fx_res_n)
    );

    logic [W-1:0] a_mag, b_mag;
    assign a_mag = fx_res_n;
    assign b_mag = fx_res_w[2*W-1:W];

    // One radix-2 step
    logic [W:0]     mul_sum;
    logic [W:0]     rem_sh;
    logic           div_ge;
    logic [W-1:0]   div_sub;
    logic [2*W-1:0] step_acc;

    assign mul_sum = {1'b0, acc[2*W-1:W]} + {1'b0, opnd & {W{acc[0]}}};
    assign rem_sh  = {acc[2*W-1:W], acc[W-1]};
    assign div_ge  = rem_sh >= {1'b0, opnd};
    // When rem_sh >= opnd the true difference is below opnd, so W bits suffice.
    assign div_sub = rem_sh[W-1:0] - opnd;

    always_comb begin
        step_acc = '0;
        if (!is_div) begin
            step_acc = {mul_sum, acc[W-1:1]};
        end else if (div_ge) begin
            step_acc = {div_sub, acc[W-2:0], 1'b1};
        end else begin
            step_acc = {rem_sh[W-1:0], acc[W-2:0], 1'b0};
        end
    end

    // FSM
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: if (issue) state_nxt = ST_RUN;
            ST_RUN:  if (cnt == '0) state_nxt = ST_FIX;
            ST_FIX:  state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Datapath and architectural registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc    <= '0;
            opnd   <= '0;
            cnt    <= '0;
            is_div <= 1'b0;
            neg_hi <= 1'b0;
            neg_lo <= 1'b0;
            hi_q   <= '0;
            lo_q   <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= (state == ST_FIX);
            unique case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        if (mul_op) begin
                            acc    <= {{W{1'b0}}, b_mag};
                            opnd   <= a_mag;
                            is_div <= 1'b0;
                            neg_hi <= sgn_op && (bus.a[W-1] ^ bus.b[W-1]);
                            neg_lo <= 1'b0;
                            cnt    <= CNT_W'(ITER - 1);
                        end else if (div_op) begin
                            acc    <= {{W{1'b0}}, a_mag};
                            opnd   <= b_mag;
                            is_div <= 1'b1;
                            neg_hi <= sgn_op && !dz && bus.a[W-1];
                            neg_lo <= sgn_op && !dz && (bus.a[W-1] ^ bus.b[W-1]);
                            cnt    <= CNT_W'(ITER - 1);
                        end else if (bus.op == OP_MTHI) begin
                            hi_q <= bus.a;
                        end else if (bus.op == OP_MTLO) begin
                            lo_q <= bus.a;
                        end
                    end
                end
                ST_RUN: begin
                    acc <= step_acc;
                    cnt <= cnt - CNT_W'(1);
                end
                ST_FIX: begin
                    hi_q <= fx_res_w[2*W-1:W];
                    lo_q <= is_div ? fx_res_n : fx_res_w[W-1:0];
                end
                default: ;
            endcase
        end
    end

    assign bus.busy = (state != ST_IDLE);
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

endmodule

// File: tb/tb_muldiv_hilo_unit.sv
module tb_muldiv_hilo_unit;
    import muldiv_pkg::*;

    logic clk = 1'b0;
    logic reset_n;

    muldiv_hilo_unit_if #(.WIDTH(32)) bus ();

    muldiv_hilo_unit #(.WIDTH(32), .ITER(32)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    localparam int NVEC = 14;
    vec_t vecs[NVEC];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents a request for exactly one rising edge (E0), returns at E0+1.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        tick();
        bus.start = 1'b0;
        bus.op    = OP_NOP;
        bus.a     = '0;
        bus.b     = '0;
    endtask

    // Counts edges after E0 until done, bounded; also counts any early busy drop.
    task automatic wait_done(output int lat, output int busy_low);
        lat      = 0;
        busy_low = 0;
        while (!bus.done && lat < 60) begin
            if (!bus.busy) busy_low++;
            tick();
            lat++;
        end
    endtask

    initial begin
        int lat;
        int bl;

        vecs[0]  = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vecs[1]  = '{OP_MULT,  32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB};
        vecs[2]  = '{OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        vecs[3]  = '{OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[4]  = '{OP_DIVU,  32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003};
        vecs[5]  = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vecs[6]  = '{OP_DIVU,  32'h00000005, 32'h00000000, 32'h00000005, 32'hFFFFFFFF};
        vecs[7]  = '{OP_DIV,   32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF};
        vecs[8]  = '{OP_MULT,  32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFF2};
        vecs[9]  = '{OP_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
        vecs[10] = '{OP_DIVU,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'hFFFFFFFF};
        vecs[11] = '{OP_MULTU, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780};
        vecs[12] = '{OP_DIV,   32'hFFFFFFF8, 32'hFFFFFFFD, 32'hFFFFFFFE, 32'h00000002};
        vecs[13] = '{OP_DIVU,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000};

        bus.start = 1'b0;
        bus.op    = OP_NOP;
        bus.a     = '0;
        bus.b     = '0;
        reset_n   = 1'b0;

        // Reset state
        #12;
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        check("rst_hi",   64'(bus.hi),   64'd0);
        check("rst_lo",   64'(bus.lo),   64'd0);
        tick();
        reset_n = 1'b1;
        tick();

        // MTHI / MTLO / NOP / reserved while idle
        issue(OP_MTHI, 32'h00001234, 32'h0);
        check("mthi_hi",   64'(bus.hi),   64'h1234);
        check("mthi_lo",   64'(bus.lo),   64'h0);
        check("mthi_done", 64'(bus.done), 64'd0);
        check("mthi_busy", 64'(bus.busy), 64'd0);
        issue(OP_MTLO, 32'h00005678, 32'h0);
        check("mtlo_lo",   64'(bus.lo),   64'h5678);
        check("mtlo_hi",   64'(bus.hi),   64'h1234);
        issue(3'b111, 32'hFFFFFFFF, 32'hFFFFFFFF);
        check("rsv_busy",  64'(bus.busy), 64'd0);
        check("rsv_hilo",  {bus.hi, bus.lo}, {32'h1234, 32'h5678});
        issue(OP_NOP, 32'hAAAAAAAA, 32'h1);
        check("nop_hilo",  {bus.hi, bus.lo}, {32'h1234, 32'h5678});
        tick();
        check("mt_nodone", 64'(bus.done), 64'd0);

        // Table-driven arithmetic
        for (int i = 0; i < NVEC; i++) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b);
            wait_done(lat, bl);
            check($sformatf("v%0d_lat", i),    64'(lat),      64'd33);
            check($sformatf("v%0d_busyrun", i), 64'(bl),      64'd0);
            check($sformatf("v%0d_busy", i),   64'(bus.busy), 64'd0);
            check($sformatf("v%0d_hi", i),     64'(bus.hi),   64'(vecs[i].hi));
            check($sformatf("v%0d_lo", i),     64'(bus.lo),   64'(vecs[i].lo));
            tick();
            check($sformatf("v%0d_pulse", i),  64'(bus.done), 64'd0);
        end

        // Start in the same cycle done is high is accepted
        issue(OP_DIVU, 32'd7, 32'd2);
        wait_done(lat, bl);
        check("b2b_first_lo", 64'(bus.lo), 64'd3);
        issue(OP_MULTU, 32'd3, 32'd4);
        check("b2b_accept_busy", 64'(bus.busy), 64'd1);
        check("b2b_accept_done", 64'(bus.done), 64'd0);
        wait_done(lat, bl);
        check("b2b_lat", 64'(lat), 64'd33);
        check("b2b_res", {bus.hi, bus.lo}, {32'd0, 32'd12});
        tick();

        // Issues while busy are dropped and do not disturb timing
        issue(OP_MULTU, 32'd3, 32'd5);
        lat = 0;
        for (int c = 0; c < 60 && !bus.done; c++) begin
            bus.start = (c == 5) || (c == 10) || (c == 15);
            bus.op    = (c == 5) ? OP_MTLO : ((c == 10) ? OP_MULT : OP_MTHI);
            bus.a     = 32'hDEADBEEF;
            bus.b     = 32'd3;
            if (c == 20) begin
                check("ign_hilo_run", {bus.hi, bus.lo}, {32'd0, 32'd12});
                check("ign_busy_run", 64'(bus.busy), 64'd1);
            end
            tick();
            lat = c + 1;
        end
        bus.start = 1'b0;
        bus.op    = OP_NOP;
        bus.a     = '0;
        bus.b     = '0;
        check("ign_lat", 64'(lat), 64'd33);
        check("ign_res", {bus.hi, bus.lo}, {32'd0, 32'd15});
        tick();
        check("ign_nostart", 64'(bus.busy), 64'd0);

        // Asynchronous reset in the middle of a divide
        issue(OP_DIV, 32'hFFFFFFF9, 32'd2);
        repeat (9) tick();
        check("mid_busy_pre", 64'(bus.busy), 64'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_busy", 64'(bus.busy), 64'd0);
        check("arst_done", 64'(bus.done), 64'd0);
        check("arst_hilo", {bus.hi, bus.lo}, 64'd0);
        tick();
        reset_n = 1'b1;
        tick();
        check("arst_idle", 64'(bus.busy), 64'd0);
        issue(OP_MULTU, 32'd3, 32'd4);
        wait_done(lat, bl);
        check("post_lat", 64'(lat), 64'd33);
        check("post_res", {bus.hi, bus.lo}, {32'd0, 32'd12});
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
